// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states, strobe constants
// and small op-classification helpers.
package mem_access_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'h0,
      OP_LH  = 4'h1,
      OP_LW  = 4'h2,
      OP_LBU = 4'h3,
      OP_LHU = 4'h4,
      OP_LWL = 4'h5,
      OP_LWR = 4'h6,
      OP_SB  = 4'h8,
      OP_SH  = 4'h9,
      OP_SW  = 4'hA,
      OP_SWL = 4'hB,
      OP_SWR = 4'hC
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_WB       = 2'd3
   } state_e;

   localparam logic [3:0] STRB_ALL     = 4'b1111;
   localparam logic [3:0] STRB_BYTE0   = 4'b0001;
   localparam logic [3:0] STRB_LO_HALF = 4'b0011;
   localparam logic [3:0] STRB_HI_HALF = 4'b1100;

   function automatic logic is_store(input mem_op_e op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
   endfunction

   // Unaligned-capable ops (LWL/LWR/SWL/SWR, bytes) are never flagged.
   function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] ea);
      return ((op inside {OP_LH, OP_LHU, OP_SH}) && ea[0]) ||
             ((op inside {OP_LW, OP_SW}) && (ea != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-request, memory-port and write-back signals of the load/store sequencer.
// slave = controller view, master = surrounding pipeline/memory view.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_strb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        op_done;
   logic        op_err;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_rd,
      input  mem_req_ready, mem_rsp_valid, mem_rdata,
      output req_ready, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_strb,
      output wb_valid, wb_rd, wb_data, op_done, op_err
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_rd,
      output mem_req_ready, mem_rsp_valid, mem_rdata,
      input  req_ready, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_strb,
      input  wb_valid, wb_rd, wb_data, op_done, op_err
   );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering: store data/strobes and extended or merged load data
// from the op, the low address bits and the word read back from memory.
module lane_align
   import mem_access_ctrl_pkg::*;
(
   input  mem_op_e     op,
   input  logic [1:0]  ea,
   input  logic [31:0] rt,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data,
   output logic [3:0]  st_strb
);
   logic [4:0]  sh_lo;
   logic [4:0]  sh_hi;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // sh_hi = 8*(3-ea): distance of byte ea from the top lane.
   assign sh_lo   = {ea, 3'b000};
   assign sh_hi   = {~ea, 3'b000};
   assign ld_byte = rdata[sh_lo +: 8];
   assign ld_half = rdata[{ea[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = rdata;
      st_data = 32'h0;
      st_strb = STRB_ALL;
      case (op)
         OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: ld_data = {24'h0, ld_byte};
         OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU: ld_data = {16'h0, ld_half};
         OP_LWL: ld_data = (rdata << sh_hi) | (rt & ~(32'hFFFF_FFFF << sh_hi));
         OP_LWR: ld_data = (rdata >> sh_lo) | (rt & ~(32'hFFFF_FFFF >> sh_lo));
         OP_SB: begin
            st_strb = STRB_BYTE0 << ea;
            st_data = {24'h0, rt[7:0]} << sh_lo;
         end
         OP_SH: begin
            st_strb = ea[1] ? STRB_HI_HALF : STRB_LO_HALF;
            st_data = {16'h0, rt[15:0]} << {ea[1], 4'b0000};
         end
         OP_SW:  st_data = rt;
         OP_SWL: begin
            st_strb = STRB_ALL >> ~ea;
            st_data = rt >> sh_hi;
         end
         OP_SWR: begin
            st_strb = STRB_ALL << ea;
            st_data = rt << sh_lo;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer between the MEM stage and the data-memory port.
// Optional MEM_ALIGN_CHK_EN: misaligned LH/LHU/SH/LW/SW are rejected with op_err without a memory access.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            resetn,
   mem_access_ctrl_if.slave bus
);
   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

   state_e            state_q, state_d;
   mem_op_e           op_q, op_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]  counter_q, counter_d;
   logic [CNT_W-1:0]  counter_inc;
   logic              timeout_hit;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              op_done_q, op_done_d;
   logic              op_err_q, op_err_d;
   logic [31:0]       ld_data;
   logic [31:0]       st_data;
   logic [3:0]        st_strb;

   lane_align u_lane_align (
      .op      (op_q),
      .ea      (addr_q[1:0]),
      .rt      (wdata_q),
      .rdata   (rdata_q),
      .ld_data (ld_data),
      .st_data (st_data),
      .st_strb (st_strb)
   );

   // The wait ends in the cycle whose increment would reach TIMEOUT_CYC, so WAIT_RSP
   // lasts at most TIMEOUT_CYC cycles; a response in that last cycle still wins.
   assign counter_inc = counter_q + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (counter_inc == TIMEOUT_VAL);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      rdata_d    = rdata_q;
      counter_d  = counter_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      op_done_d  = 1'b0;
      op_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d    = mem_op_e'(bus.req_op);
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rd_d    = bus.req_rd;
`ifdef MEM_ALIGN_CHK_EN
               if (is_misaligned(mem_op_e'(bus.req_op), bus.req_addr[1:0])) begin
                  op_err_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
`else
               state_d = ST_ISSUE;
`endif
            end
         end
         ST_ISSUE: begin
            if (bus.mem_req_ready) begin
               state_d   = ST_WAIT_RSP;
               counter_d = '0;
            end
         end
         ST_WAIT_RSP: begin
            counter_d = counter_inc;
            if (bus.mem_rsp_valid) begin
               if (is_store(op_q)) begin
                  op_done_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  rdata_d = bus.mem_rdata;
                  state_d = ST_WB;
               end
            end else if (timeout_hit) begin
               op_err_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_WB: begin
            wb_valid_d = 1'b1;
            op_done_d  = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_data;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_LB;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rd_q       <= 5'h0;
         rdata_q    <= 32'h0;
         counter_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'h0;
         wb_data_q  <= 32'h0;
         op_done_q  <= 1'b0;
         op_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         rdata_q    <= rdata_d;
         counter_q  <= counter_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         op_done_q  <= op_done_d;
         op_err_q   <= op_err_d;
      end
   end

   assign bus.req_ready     = (state_q == ST_IDLE);
   assign bus.mem_req_valid = (state_q == ST_ISSUE);
   assign bus.mem_wen       = is_store(op_q);
   assign bus.mem_addr      = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata     = st_data;
   assign bus.mem_strb      = st_strb;
   assign bus.wb_valid      = wb_valid_q;
   assign bus.wb_rd         = wb_rd_q;
   assign bus.wb_data       = wb_data_q;
   assign bus.op_done       = op_done_q;
   assign bus.op_err        = op_err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-level reference model; honours MEM_ALIGN_CHK_EN.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        resetn;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] last_wb;
   logic [31:0] last_wdata;
   logic [31:0] last_addr;
   logic [3:0]  last_strb;

   mem_access_ctrl_if bus();

   mem_access_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit st_op(input mem_op_e op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
   endfunction

   function automatic bit misaligned(input mem_op_e op, input logic [1:0] k);
      return ((op == OP_LH || op == OP_LHU || op == OP_SH) && k[0]) ||
             ((op == OP_LW || op == OP_SW) && k != 2'd0);
   endfunction

   // Byte-array model: exp_word is the load result for loads, the bus store word for stores.
   function automatic void model(input mem_op_e op, input logic [31:0] addr, input logic [31:0] rt,
                                 input logic [31:0] rdata, output logic [31:0] exp_word,
                                 output logic [3:0] exp_strb);
      int k;
      int base;
      logic [7:0] m [4];
      logic [7:0] r [4];
      logic [7:0] o [4];
      k = int'(addr[1:0]);
      base = (k / 2) * 2;
      for (int i = 0; i < 4; i++) begin
         m[i] = rdata[8*i +: 8];
         r[i] = rt[8*i +: 8];
         o[i] = 8'h00;
      end
      exp_strb = 4'b1111;
      case (op)
         OP_LB, OP_LBU: begin
            o[0] = m[k];
            if (op == OP_LB && m[k][7]) for (int i = 1; i < 4; i++) o[i] = 8'hFF;
         end
         OP_LH, OP_LHU: begin
            o[0] = m[base];
            o[1] = m[base+1];
            if (op == OP_LH && m[base+1][7]) begin o[2] = 8'hFF; o[3] = 8'hFF; end
         end
         OP_LW: for (int i = 0; i < 4; i++) o[i] = m[i];
         OP_LWL: begin
            for (int i = 0; i < 4; i++) o[i] = r[i];
            for (int i = 0; i <= k; i++) o[3-i] = m[k-i];
         end
         OP_LWR: begin
            for (int i = 0; i < 4; i++) o[i] = r[i];
            for (int i = k; i < 4; i++) o[i-k] = m[i];
         end
         OP_SB: begin
            exp_strb = 4'b0000; exp_strb[k] = 1'b1; o[k] = r[0];
         end
         OP_SH: begin
            exp_strb = 4'b0000; exp_strb[base] = 1'b1; exp_strb[base+1] = 1'b1;
            o[base] = r[0]; o[base+1] = r[1];
         end
         OP_SW: for (int i = 0; i < 4; i++) o[i] = r[i];
         OP_SWL: begin
            exp_strb = 4'b0000;
            for (int i = 0; i <= k; i++) begin o[i] = r[3-k+i]; exp_strb[i] = 1'b1; end
         end
         OP_SWR: begin
            exp_strb = 4'b0000;
            for (int i = k; i < 4; i++) begin o[i] = r[i-k]; exp_strb[i] = 1'b1; end
         end
         default: ;
      endcase
      exp_word = {o[3], o[2], o[1], o[0]};
   endfunction

   // Entered and left at posedge+1 with the controller idle.
   task automatic run_op(input mem_op_e op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input int issue_wait, input int rsp_wait, input bit no_rsp);
      logic [31:0] e_word;
      logic [3:0]  e_strb;
      logic [31:0] e_addr;
      bit          err_exp;
      bit          st;
      int unsigned acc_cyc;
      model(op, addr, rt, rdata, e_word, e_strb);
      e_addr  = {addr[31:2], 2'b00};
      st      = st_op(op);
      err_exp = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
      err_exp = misaligned(op, addr[1:0]);
`endif
      $display("op=%s addr=%h rt=%h rd=%0d rdata=%h iw=%0d rw=%0d norsp=%0d",
               op.name(), addr, rt, rd, rdata, issue_wait, rsp_wait, no_rsp);
      chk("idle_ready", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = rt;
      bus.req_rd    = rd;
      tick();
      acc_cyc = cyc;
      bus.req_valid = 1'b0;
      if (err_exp) begin
         chk("align_err", {bus.op_err, bus.mem_req_valid, bus.req_ready}, 3'b101);
         tick();
         chk("align_err_end", {bus.op_err, bus.mem_req_valid, bus.op_done}, 3'b000);
         return;
      end
      chk("issue", {bus.mem_req_valid, bus.mem_wen, bus.mem_strb, bus.req_ready}, {1'b1, st, e_strb, 1'b0});
      chk("issue_addr", bus.mem_addr, e_addr);
      last_addr = bus.mem_addr;
      last_strb = bus.mem_strb;
      last_wdata = bus.mem_wdata;
      if (st) chk("issue_wdata", bus.mem_wdata, e_word);
      for (int c = 0; c < issue_wait; c++) begin
         bus.mem_rsp_valid = 1'($urandom_range(0, 1));
         bus.mem_rdata     = $urandom;
         bus.req_valid     = 1'($urandom_range(0, 1));
         bus.req_op        = 4'($urandom);
         bus.req_addr      = $urandom;
         bus.req_wdata     = $urandom;
         tick();
         chk("issue_hold", {bus.mem_req_valid, bus.req_ready, bus.mem_strb, bus.mem_addr, bus.mem_wdata},
             {1'b1, 1'b0, e_strb, e_addr, last_wdata});
      end
      bus.req_valid     = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      chk("wait_state", {bus.mem_req_valid, bus.req_ready}, 2'b00);
      if (no_rsp) begin
         for (int c = 1; c < TMO; c++) begin
            tick();
            chk("tmo_early", bus.op_err, 1'b0);
         end
         tick();
         chk("tmo_err", {bus.op_err, bus.req_ready, bus.wb_valid, bus.op_done}, 4'b1100);
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rdata     = rdata;
         tick();
         bus.mem_rsp_valid = 1'b0;
         chk("late_rsp", {bus.op_err, bus.wb_valid, bus.op_done, bus.req_ready}, 4'b0001);
         tick();
         chk("late_rsp2", {bus.wb_valid, bus.op_done}, 2'b00);
         return;
      end
      for (int c = 0; c < rsp_wait; c++) tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = rdata;
      tick();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = $urandom;
      if (st) begin
         chk("st_done", {bus.op_done, bus.wb_valid, bus.op_err, bus.req_ready}, 4'b1001);
         tick();
         chk("st_done_pulse", {bus.op_done, bus.wb_valid}, 2'b00);
      end else begin
         chk("ld_wb_state", {bus.op_done, bus.wb_valid, bus.req_ready}, 3'b000);
         tick();
         chk("ld_wb", {bus.wb_valid, bus.op_done, bus.op_err}, 3'b110);
         chk("ld_data", bus.wb_data, e_word);
         chk("ld_rd", bus.wb_rd, rd);
         chk("ld_latency", cyc - acc_cyc, 3 + issue_wait + rsp_wait);
         last_wb = bus.wb_data;
         tick();
         chk("ld_wb_pulse", {bus.wb_valid, bus.op_done}, 2'b00);
      end
   endtask

   initial begin
      mem_op_e ops [12] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWL, OP_LWR,
                            OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
      resetn            = 1'b0;
      bus.req_valid     = 1'b0;
      bus.req_op        = 4'h0;
      bus.req_addr      = 32'h0;
      bus.req_wdata     = 32'h0;
      bus.req_rd        = 5'h0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = 32'h0;
      last_wb = 32'h0; last_wdata = 32'h0; last_addr = 32'h0; last_strb = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {bus.req_ready, bus.mem_req_valid, bus.wb_valid, bus.op_done, bus.op_err}, 5'b10000);
      chk("rst_wb", {bus.wb_rd, bus.wb_data}, 37'h0);
      resetn = 1'b1;
      tick();

      run_op(OP_LB, 32'h0000_1003, 32'h1234_5678, 5'd7, 32'h80FF_0000, 0, 0, 1'b0);
      chk("lb_example", last_wb, 32'hFFFF_FF80);
      run_op(OP_SWL, 32'h0000_2001, 32'hAABB_CCDD, 5'd1, 32'h0, 0, 0, 1'b0);
      chk("swl_example", {last_addr, last_strb, last_wdata}, {32'h0000_2000, 4'b0011, 32'h0000_AABB});
      run_op(OP_LWR, 32'h0000_3002, 32'h1122_3344, 5'd9, 32'hDEAD_BEEF, 0, 0, 1'b0);
      chk("lwr_example", last_wb, 32'h1122_DEAD);
      run_op(OP_SW, 32'h0000_6004, 32'hCAFE_F00D, 5'd2, 32'h0, 5, 1, 1'b0);
      run_op(OP_LW, 32'h0000_7000, 32'h0, 5'd3, 32'h5555_AAAA, 0, 0, 1'b1);
      run_op(OP_LH, 32'h0000_8002, 32'h0, 5'd4, 32'h8001_7FFF, 1, TMO - 1, 1'b0);
      run_op(OP_LW, 32'h0000_4002, 32'h0, 5'd5, 32'h0BAD_F00D, 0, 0, 1'b0);

      // Reset while a load waits for its response.
      bus.req_valid = 1'b1;
      bus.req_op    = OP_LW;
      bus.req_addr  = 32'h0000_5000;
      bus.req_rd    = 5'd11;
      tick();
      bus.req_valid     = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("midrst_ctrl", {bus.req_ready, bus.mem_req_valid, bus.wb_valid, bus.op_done, bus.op_err}, 5'b10000);
      chk("midrst_wb", {bus.wb_rd, bus.wb_data}, 37'h0);
      @(negedge clk);
      resetn            = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'h1357_9BDF;
      tick();
      bus.mem_rsp_valid = 1'b0;
      chk("midrst_after", {bus.wb_valid, bus.op_done, bus.req_ready}, 3'b001);
      tick();
      chk("midrst_after2", {bus.wb_valid, bus.op_done, bus.mem_req_valid}, 3'b000);

      for (int t = 0; t < 80; t++) begin
         run_op(ops[$urandom_range(0, 11)], $urandom, $urandom, 5'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, TMO - 1), ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
